// File: rtl/picorv32_mem_model.sv
// PicoRV32 native-bus RAM + MMIO responder (console, done/exit code) with LATENCY wait states.
// mem_ready pulses LATENCY+1 cycles after accept; requests must hold mem_valid until mem_ready.
module picorv32_mem_model #(
  parameter int          ADDR_WIDTH = 14,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        done,
  output logic [31:0] done_code,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [31:0]             addr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wstrb_q;
  logic                    instr_q;
  logic [31:0]             ram [0:(1<<ADDR_WIDTH)-1];

  logic                    in_idle;
  logic [31:0]             addr_e;
  logic [31:0]             wdata_e;
  logic [3:0]              wstrb_e;
  logic [31:0]             word_addr;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    fire;
  logic                    is_wr;
  logic                    is_ram;
  logic                    is_con;
  logic                    is_done;
  logic                    misaligned;
  logic                    unused_instr;

  // Decode straight from the bus while idle so LATENCY=0 can respond on the next cycle.
  assign in_idle    = (state == S_IDLE);
  assign addr_e     = in_idle ? mem_addr  : addr_q;
  assign wdata_e    = in_idle ? mem_wdata : wdata_q;
  assign wstrb_e    = in_idle ? mem_wstrb : wstrb_q;
  assign fire       = mem_valid && ((in_idle && LATENCY == 0) ||
                                    (state == S_WAIT && cnt == 4'd1));
  assign is_wr      = |wstrb_e;
  assign word_addr  = {addr_e[31:2], 2'b00};
  assign is_ram     = (addr_e[31:ADDR_WIDTH+2] == '0);
  assign is_con     = (word_addr == MMIO_BASE);
  assign is_done    = (word_addr == MMIO_BASE + 32'd4);
  assign misaligned = (addr_e[1:0] != 2'b00);
  assign idx        = addr_e[ADDR_WIDTH+1:2];
  assign unused_instr = ^{mem_instr, instr_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      instr_q   <= 1'b0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'd0;
      done      <= 1'b0;
      done_code <= 32'd0;
      err       <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
      tx_valid  <= 1'b0;
      case (state)
        S_IDLE: if (mem_valid) begin
          addr_q  <= mem_addr;
          wdata_q <= mem_wdata;
          wstrb_q <= mem_wstrb;
          instr_q <= mem_instr;
          cnt     <= 4'(LATENCY);
          state   <= (LATENCY == 0) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          if (!mem_valid) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else if (cnt == 4'd1) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (fire) begin
        mem_ready <= 1'b1;
        if (misaligned) err <= 1'b1;
        if (is_ram) begin
          mem_rdata <= is_wr ? 32'd0 : ram[idx];
        end else if (is_con) begin
          if (is_wr) begin
            tx_valid <= 1'b1;
            tx_data  <= wdata_e[7:0];
          end
        end else if (is_done) begin
          if (is_wr) begin
            done <= 1'b1;
            if (!done) done_code <= wdata_e;
          end
        end else begin
          err <= 1'b1;
          if (!is_wr) mem_rdata <= 32'hDEAD_BEEF;
        end
      end
    end
  end

  // RAM is deliberately not reset so a harness can preload it.
  always_ff @(posedge clk) begin
    if (!rst && fire && is_ram && is_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_e[i]) ram[idx][8*i +: 8] <= wdata_e[8*i +: 8];
      end
    end
  end

endmodule
